// File: rtl/i2s_pkg.sv
// I2S transmitter shared definitions.
// Default word width and the slot-index type.
package i2s_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned WIDTH_MAX = 32;

  // Wide enough for 2*WIDTH slots at the largest legal width
  localparam int unsigned SLOT_W = $clog2(2 * WIDTH_MAX);

  typedef logic [SLOT_W-1:0] slot_t;

endpackage

// File: rtl/i2s_tx_if.sv
// I2S transmitter sample handshake and serial outputs.
// master = sample source, slave = transmitter.
interface i2s_tx_if
  import i2s_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);

  logic             en_i;
  logic [WIDTH-1:0] leftChan_i;
  logic [WIDTH-1:0] rightChan_i;
  logic             valid_i;
  logic             ready_o;
  logic             ws_o;
  logic             sdata_o;
  logic             pktI2STxLoaded_o;
  logic             underrun_o;

  modport master (
    output en_i, leftChan_i, rightChan_i, valid_i,
    input  ready_o, ws_o, sdata_o,
    input  pktI2STxLoaded_o, underrun_o
  );

  modport slave (
    input  en_i, leftChan_i, rightChan_i, valid_i,
    output ready_o, ws_o, sdata_o,
    output pktI2STxLoaded_o, underrun_o
  );

endinterface

// File: rtl/i2s_tx.sv
// I2S transmitter: one-deep pending buffer, active pair,
// slot counter; all state moves on the falling edge of sclk_i.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input logic   sclk_i,
  input logic   rstN_i,
  i2s_tx_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam slot_t LAST   = slot_t'(2 * WIDTH - 1);
  localparam slot_t W_SLOT = slot_t'(WIDTH);
  // May wrap to 0 at the widest setting; the index math is modular
  localparam slot_t F_SLOT = slot_t'(2 * WIDTH);

  slot_t            slot, slot_n;
  logic [WIDTH-1:0] act_l, act_l_n;
  logic [WIDTH-1:0] act_r, act_r_n;
  logic [WIDTH-1:0] pend_l, pend_l_n;
  logic [WIDTH-1:0] pend_r, pend_r_n;
  logic             pend_empty, pend_empty_n;
  logic             load_q, load_n;
  logic             unf_q, unf_n;
  logic [IDX_W-1:0] bit_idx;
  logic             sdata_c;

  // Next state: handshake, frame counter, load/underrun at s=1
  always_comb begin
    slot_n       = slot;
    act_l_n      = act_l;
    act_r_n      = act_r;
    pend_l_n     = pend_l;
    pend_r_n     = pend_r;
    pend_empty_n = pend_empty;
    load_n       = 1'b0;
    unf_n        = 1'b0;
    if (bus.valid_i && pend_empty) begin
      pend_l_n     = bus.leftChan_i;
      pend_r_n     = bus.rightChan_i;
      pend_empty_n = 1'b0;
    end
    if (!bus.en_i) begin
      slot_n  = '0;
      act_l_n = '0;
      act_r_n = '0;
    end else begin
      slot_n = (slot == LAST) ? '0 : slot + 1'b1;
      if (slot == '0) begin
        if (!pend_empty) begin
          act_l_n      = pend_l;
          act_r_n      = pend_r;
          pend_empty_n = 1'b1;
          load_n       = 1'b1;
        end else begin
          act_l_n = '0;
          act_r_n = '0;
          unf_n   = 1'b1;
        end
      end
    end
  end

  // State registers on the falling bit-clock edge
  always_ff @(negedge sclk_i or negedge rstN_i) begin
    if (!rstN_i) begin
      slot       <= '0;
      act_l      <= '0;
      act_r      <= '0;
      pend_l     <= '0;
      pend_r     <= '0;
      pend_empty <= 1'b1;
      load_q     <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      slot       <= slot_n;
      act_l      <= act_l_n;
      act_r      <= act_r_n;
      pend_l     <= pend_l_n;
      pend_r     <= pend_r_n;
      pend_empty <= pend_empty_n;
      load_q     <= load_n;
      unf_q      <= unf_n;
    end
  end

  // Bit select: s=0 finishes the previous right word
  always_comb begin
    bit_idx = '0;
    sdata_c = 1'b0;
    if (slot == '0) begin
      sdata_c = act_r[0];
    end else if (slot <= W_SLOT) begin
      bit_idx = IDX_W'(W_SLOT - slot);
      sdata_c = act_l[bit_idx];
    end else begin
      bit_idx = IDX_W'(F_SLOT - slot);
      sdata_c = act_r[bit_idx];
    end
  end

  assign bus.ready_o          = pend_empty;
  assign bus.ws_o             = (slot >= W_SLOT);
  assign bus.sdata_o          = sdata_c;
  assign bus.pktI2STxLoaded_o = load_q;
  assign bus.underrun_o       = unf_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: rising-edge loopback receiver
// checked against a queue of expected sample pairs.
module tb_i2s_tx;
  import i2s_pkg::*;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] l;
    logic [W-1:0] r;
  } pair_t;

  logic sclk = 1'b0;
  logic rstN = 1'b0;

  i2s_tx_if #(.WIDTH(W)) bus ();

  i2s_tx #(.WIDTH(W)) dut (
    .sclk_i (sclk),
    .rstN_i (rstN),
    .bus    (bus)
  );

  always #5 sclk = ~sclk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  pair_t        exp_q[$];
  int           rise_t[$];
  logic         ws_d = 1'b0;
  logic [W-1:0] sh_l = '0;
  logic [W-1:0] sh_r = '0;
  logic [W-1:0] rx_l = '0;
  bit           rx_on = 1'b0;
  int           cyc = 0;
  int           n_load = 0;
  int           n_unf = 0;

  // Rising-edge receiver: channel is ws one cycle late
  always @(posedge sclk) begin
    pair_t e;
    cyc++;
    if (bus.pktI2STxLoaded_o) n_load++;
    if (bus.underrun_o) n_unf++;
    if (bus.ws_o && !ws_d) rise_t.push_back(cyc);
    if (ws_d) sh_r = {sh_r[W-2:0], bus.sdata_o};
    else      sh_l = {sh_l[W-2:0], bus.sdata_o};
    if (rx_on && (bus.ws_o != ws_d)) begin
      if (!ws_d) begin
        rx_l = sh_l;
      end else begin
        chk("rx_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rx_left", rx_l, e.l);
          chk("rx_right", sh_r, e.r);
        end
      end
    end
    ws_d = bus.ws_o;
  end

  task automatic send_idle(logic [W-1:0] l, logic [W-1:0] r,
                           bit push);
    bus.valid_i     = 1'b1;
    bus.leftChan_i  = l;
    bus.rightChan_i = r;
    if (push) exp_q.push_back('{l: l, r: r});
    @(negedge sclk);
    @(posedge sclk);
    #1;
    chk("acc_ready_low", bus.ready_o, 1'b0);
    bus.valid_i = 1'b0;
  endtask

  task automatic run_frames(int n);
    repeat (n * 2 * W) @(negedge sclk);
    @(posedge sclk);
    #1;
    bus.en_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    bit got;
    bus.en_i        = 1'b0;
    bus.valid_i     = 1'b0;
    bus.leftChan_i  = '0;
    bus.rightChan_i = '0;
    repeat (3) @(posedge sclk);
    #1;
    chk("rst_ready", bus.ready_o, 1'b1);
    chk("rst_ws", bus.ws_o, 1'b0);
    chk("rst_sdata", bus.sdata_o, 1'b0);
    chk("rst_load", bus.pktI2STxLoaded_o, 1'b0);
    chk("rst_unf", bus.underrun_o, 1'b0);
    rstN = 1'b1;
    @(posedge sclk);
    #1;
    rx_on = 1'b1;

    // Single pair
    send_idle(16'hA5C3, 16'h1234, 1'b1);
    n_load = 0;
    n_unf  = 0;
    bus.en_i = 1'b1;
    @(posedge sclk);
    #1;
    chk("load_at_s1", bus.pktI2STxLoaded_o, 1'b1);
    chk("msb_first", bus.sdata_o, 1'b1);
    chk("ready_freed", bus.ready_o, 1'b1);
    @(posedge sclk);
    #1;
    chk("load_one_cycle", bus.pktI2STxLoaded_o, 1'b0);
    repeat (2 * W - 2) @(negedge sclk);
    @(posedge sclk);
    #1;
    bus.en_i = 1'b0;
    chk("single_loads", n_load, 1);
    chk("single_unf", n_unf, 0);

    // Back-to-back pairs, valid held high
    rise_t.delete();
    bus.valid_i     = 1'b1;
    bus.leftChan_i  = 16'h0001;
    bus.rightChan_i = 16'h8000;
    exp_q.push_back('{l: 16'h0001, r: 16'h8000});
    @(negedge sclk);
    @(posedge sclk);
    #1;
    chk("b2b_ready_drop1", bus.ready_o, 1'b0);
    bus.leftChan_i  = 16'h7FFF;
    bus.rightChan_i = 16'hFFFF;
    exp_q.push_back('{l: 16'h7FFF, r: 16'hFFFF});
    n_load = 0;
    n_unf  = 0;
    bus.en_i = 1'b1;
    fork
      run_frames(2);
      begin
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
          @(posedge sclk);
          if (bus.ready_o) begin
            @(negedge sclk);
            @(posedge sclk);
            #1;
            chk("b2b_ready_drop2", bus.ready_o, 1'b0);
            bus.valid_i = 1'b0;
            got = 1'b1;
          end
        end
        chk("b2b_accept", got, 1'b1);
        bus.valid_i = 1'b0;
      end
    join
    chk("b2b_loads", n_load, 2);
    chk("b2b_unf", n_unf, 0);
    chk("ws_rises", rise_t.size(), 2);
    if (rise_t.size() >= 2)
      chk("ws_period", rise_t[1] - rise_t[0], 2 * W);

    // Underrun: one pair then two empty frames
    send_idle(16'h5A5A, 16'hC3C3, 1'b1);
    exp_q.push_back('{l: '0, r: '0});
    exp_q.push_back('{l: '0, r: '0});
    n_load = 0;
    n_unf  = 0;
    bus.en_i = 1'b1;
    run_frames(3);
    chk("unf_loads", n_load, 1);
    chk("unf_count", n_unf, 2);

    // Asynchronous reset mid-frame
    send_idle(16'hFFFF, 16'hFFFF, 1'b0);
    bus.en_i = 1'b1;
    repeat (9) @(negedge sclk);
    @(posedge sclk);
    #1;
    chk("pre_rst_sdata", bus.sdata_o, 1'b1);
    rx_on = 1'b0;
    rstN  = 1'b0;
    #1;
    chk("arst_ws", bus.ws_o, 1'b0);
    chk("arst_sdata", bus.sdata_o, 1'b0);
    chk("arst_ready", bus.ready_o, 1'b1);
    chk("arst_load", bus.pktI2STxLoaded_o, 1'b0);
    chk("arst_unf", bus.underrun_o, 1'b0);
    bus.en_i = 1'b0;
    @(posedge sclk);
    #1;
    rstN = 1'b1;
    @(posedge sclk);
    #1;
    rx_on = 1'b1;
    exp_q.push_back('{l: '0, r: '0});
    n_load = 0;
    n_unf  = 0;
    bus.en_i = 1'b1;
    run_frames(1);
    chk("post_rst_loads", n_load, 0);
    chk("post_rst_unf", n_unf, 1);

    // Disabled with a pair pending
    send_idle(16'h1357, 16'h2468, 1'b1);
    n_load = 0;
    n_unf  = 0;
    bad    = 0;
    repeat (40) begin
      @(posedge sclk);
      if (bus.ws_o || bus.sdata_o ||
          bus.pktI2STxLoaded_o || bus.underrun_o)
        bad++;
    end
    #1;
    chk("dis_quiet", bad, 0);
    chk("dis_pending", bus.ready_o, 1'b0);
    bus.en_i = 1'b1;
    run_frames(1);
    chk("dis_loads", n_load, 1);
    chk("dis_unf", n_unf, 0);

    repeat (3) @(posedge sclk);
    #1;
    chk("rx_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
